// File: rtl/uart_word_transmitter.sv
// Serial transmit engine: sends a 16-bit word as back-to-back 8N1 frames,
// low byte first, LSB first within each byte.
module uart_word_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned WORD_BYTES   = 2
) (
   input  logic        clk_auto,
   input  logic        n_reset,
   input  logic        send,
   input  logic [15:0] tx_data,
   output logic        uart_tx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic        LAST_BYTE = (WORD_BYTES > 1) ? 1'b1 : 1'b0;

   state_t      state_q, state_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [2:0]  bit_q, bit_d;
   logic        byte_q, byte_d;
   logic [15:0] baud_q, baud_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] word_q, word_d;
   logic        send_q, send_d;
   logic        rise;
   logic        baud_end;

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      bit_d    = bit_q;
      byte_d   = byte_q;
      baud_d   = baud_q;
      shift_d  = shift_q;
      word_d   = word_q;
      send_d   = send;
      rise     = send & ~send_q;
      baud_end = (baud_q == BAUD_LAST);

      unique case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (rise) begin
               word_d  = tx_data;
               shift_d = tx_data[7:0];
               byte_d  = 1'b0;
               baud_d  = '0;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               // Next frame follows the stop bit with no idle gap.
               if (byte_q != LAST_BYTE) begin
                  byte_d  = byte_q + 1'b1;
                  shift_d = word_q[15:8];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // send_q resets high so a level held across reset release is not an edge.
   always_ff @(posedge clk_auto) begin
      if (!n_reset) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bit_q   <= '0;
         byte_q  <= 1'b0;
         baud_q  <= '0;
         shift_q <= '0;
         word_q  <= '0;
         send_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         baud_q  <= baud_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         send_q  <= send_d;
      end
   end

   assign uart_tx = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Scoreboard bench: two transmitters (2-byte and 1-byte words), frames
// decoded off the serial line and checked against queued expectations.
module tb_uart_word_transmitter;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [1:0]  send;
   logic [15:0] tx_a;
   logic [15:0] tx_b;
   logic [1:0]  line_s;
   logic [1:0]  busy_s;
   logic [1:0]  done_s;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_word_transmitter #(
      .CLKS_PER_BIT(C),
      .WORD_BYTES(2)
   ) dut_a (
      .clk_auto(clk),
      .n_reset(n_reset),
      .send(send[0]),
      .tx_data(tx_a),
      .uart_tx(line_s[0]),
      .busy(busy_s[0]),
      .done(done_s[0])
   );

   uart_word_transmitter #(
      .CLKS_PER_BIT(C),
      .WORD_BYTES(1)
   ) dut_b (
      .clk_auto(clk),
      .n_reset(n_reset),
      .send(send[1]),
      .tx_data(tx_b),
      .uart_tx(line_s[1]),
      .busy(busy_s[1]),
      .done(done_s[1])
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event not matched by expectation", name);
   endtask

   for (genvar g = 0; g < 2; g++) begin : mon
      logic [7:0] eb[$];
      int         el[$];
      int         off = 0;
      bit         inframe = 1'b0;
      logic [7:0] sh = '0;
      int         brun = 0;

      always @(negedge clk) begin
         if (n_reset !== 1'b1) begin
            inframe = 1'b0;
            brun    = 0;
            off     = 0;
         end else begin
            if (!inframe && line_s[g] === 1'b0) begin
               inframe = 1'b1;
               off     = 0;
            end
            if (inframe) begin
               if (off == C / 2) begin
                  chk($sformatf("start_bit%0d", g), 32'(line_s[g]), 0);
               end else if (off > C && off < 9 * C && off % C == C / 2) begin
                  sh = {line_s[g], sh[7:1]};
               end else if (off == 9 * C + C / 2) begin
                  chk($sformatf("stop_bit%0d", g), 32'(line_s[g]), 1);
                  if (eb.size() == 0)
                     miss($sformatf("unexpected_frame%0d", g));
                  else
                     chk($sformatf("byte%0d", g), 32'(sh),
                         32'(eb.pop_front()));
                  inframe = 1'b0;
               end
               off++;
            end
            if (busy_s[g] === 1'b1) brun++;
            if (done_s[g] === 1'b1) begin
               chk($sformatf("busy_in_done%0d", g), 32'(busy_s[g]), 0);
               if (el.size() == 0)
                  miss($sformatf("unexpected_done%0d", g));
               else
                  chk($sformatf("busy_len%0d", g), 32'(brun),
                      32'(el.pop_front()));
               brun = 0;
            end
         end
      end
   end

   task automatic wait_done(input int ch, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (done_s[ch] === 1'b1) return;
      end
      miss($sformatf("timeout_done%0d", ch));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_reset = 1'b0;
      send    = 2'b11;
      tx_a    = '0;
      tx_b    = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_tx%0d", i), 32'(line_s[i]), 1);
         chk($sformatf("rst_busy%0d", i), 32'(busy_s[i]), 0);
         chk($sformatf("rst_done%0d", i), 32'(done_s[i]), 0);
      end
      // release with send still high: no edge, no frame
      n_reset = 1'b1;
      repeat (20) tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("held_tx%0d", i), 32'(line_s[i]), 1);
         chk($sformatf("held_busy%0d", i), 32'(busy_s[i]), 0);
      end

      send = 2'b00;
      tick();
      tx_a    = 16'hA53C;
      send[0] = 1'b1;
      mon[0].eb.push_back(8'h3C);
      mon[0].eb.push_back(8'hA5);
      mon[0].el.push_back(80);
      tick();
      chk("latency_tx", 32'(line_s[0]), 0);
      chk("latency_busy", 32'(busy_s[0]), 1);

      // new request mid-word must be dropped
      repeat (20) tick();
      send[0] = 1'b0;
      tick();
      send[0] = 1'b1;
      tx_a    = 16'h1111;
      tick();
      send[0] = 1'b0;

      wait_done(0, 200);
      chk("done_cycle_tx", 32'(line_s[0]), 1);
      send[0] = 1'b1;
      tx_a    = 16'h00FF;
      mon[0].eb.push_back(8'hFF);
      mon[0].eb.push_back(8'h00);
      mon[0].el.push_back(80);
      tick();
      chk("b2b_tx", 32'(line_s[0]), 0);
      chk("b2b_busy", 32'(busy_s[0]), 1);
      chk("b2b_done", 32'(done_s[0]), 0);
      send[0] = 1'b0;
      wait_done(0, 200);

      send[1] = 1'b1;
      tx_b    = 16'hBE81;
      mon[1].eb.push_back(8'h81);
      mon[1].el.push_back(40);
      wait_done(1, 100);
      send[1] = 1'b0;

      // abort during data bit 3 of byte 0
      tick();
      send[0] = 1'b1;
      tx_a    = 16'h1234;
      repeat (17) tick();
      n_reset = 1'b0;
      send[0] = 1'b0;
      tick();
      chk("abort_tx", 32'(line_s[0]), 1);
      chk("abort_busy", 32'(busy_s[0]), 0);
      chk("abort_done", 32'(done_s[0]), 0);
      repeat (2) tick();
      n_reset = 1'b1;
      repeat (10) tick();
      chk("post_abort_done", 32'(done_s[0]), 0);

      send[0] = 1'b1;
      tx_a    = 16'h5A69;
      mon[0].eb.push_back(8'h69);
      mon[0].eb.push_back(8'h5A);
      mon[0].el.push_back(80);
      tick();
      chk("fresh_tx", 32'(line_s[0]), 0);
      send[0] = 1'b0;
      wait_done(0, 200);

      repeat (5) tick();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            chk("left_bytes0", 32'(mon[0].eb.size()), 0);
            chk("left_words0", 32'(mon[0].el.size()), 0);
         end else begin
            chk("left_bytes1", 32'(mon[1].eb.size()), 0);
            chk("left_words1", 32'(mon[1].el.size()), 0);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_word_transmitter.md
Name: uart_word_transmitter

Overview:
- Serial transmit engine for the core's UART link, the sending end of the 16-bit receive path that feeds the input mux.
- Lets one BMCORE, or a test host built from the same RTL, drive another core's uart_rx.
- Captures a 16-bit word on a rising edge of the control unit's send strobe.
- Serializes the word as WORD_BYTES back-to-back 8N1 frames, least-significant byte first, LSB first within each byte.
- Reports progress through busy/done.

Parameters:
- CLKS_PER_BIT, 5208, clk_auto cycles per bit period (50 MHz / 9600 baud); legal range 2..65535.
- WORD_BYTES, 2, number of bytes sent per word; legal 1..2; a byte index at or above WORD_BYTES is never sent.

Ports:
- clk_auto  input  1  system clock (pin Y2 domain); all logic rising-edge.
- n_reset  input  1  synchronous active-low reset; sampled on clk_auto rising edge.
- send  input  1  transmit request level from control unit; only its rising edge acts.
- tx_data  input  16  word to transmit; sampled only on the accepted send edge.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high from the cycle after acceptance until the last stop bit ends.
- done  output  1  one-cycle pulse when the whole word has been sent.

Behaviour:
- Reset (n_reset=0 at an edge): state=IDLE, uart_tx=1, busy=0, done=0, bit counter=0, byte index=0, baud counter=0, shift register=0, send_q=1.
  - send_q=1 at reset means a send level held high across reset release does NOT trigger.
  - Reset mid-frame aborts immediately; uart_tx returns high on the same edge, and no done is produced.
- Edge detect: send_q <= send every cycle; rise = send & ~send_q.
- Acceptance: rise while state==IDLE → latch tx_data into word_reg, load byte 0, enter START.
  - Next cycle: uart_tx=0 and busy=1; latency is 1 cycle from the sampled edge.
  - A rise while not IDLE is ignored, with no queueing. tx_data changes after acceptance have no effect.
- State machine (registered outputs; baud counter counts 0..CLKS_PER_BIT-1; each state lasts exactly CLKS_PER_BIT cycles per bit):
  - IDLE: uart_tx=1, busy=0.
  - START: uart_tx=0 for one bit period, then DATA with bit index 0.
  - DATA: uart_tx=shift[0] for one bit period per bit. The shift register shifts right at each period end. After bit index 7 completes, go to STOP.
  - STOP: uart_tx=1 for one bit period. Then:
    - If byte index < WORD_BYTES-1: increment byte index, load word_reg[15:8], go to START with no inter-frame gap.
    - Otherwise go to IDLE and pulse done=1 for exactly one cycle; busy=0 in that same cycle.
- Frame timing: total word time = WORD_BYTES×10×CLKS_PER_BIT cycles from the first uart_tx low to the done cycle.
- Back-to-back sends:
  - A rise sampled in the done cycle is accepted, because state is IDLE; done and the new busy do not overlap.
  - The minimum idle-high gap between words is 1 cycle.
- No parity, single stop bit, no flow control. A byte is never truncated except by reset.

Test Plan:
- Reset/idle: hold n_reset=0 for 3 cycles with send=1 throughout, then release with send held at 1 → uart_tx=1, busy=0, done=0 and no transmission (edge suppressed).
- Single word, CLKS_PER_BIT=4, WORD_BYTES=2, tx_data=16'hA53C:
  - uart_tx emits start 0, bits 0,0,1,1,1,1,0,0 (0x3C LSB first), stop 1, then start 0, bits 1,0,1,0,0,1,0,1 (0xA5), stop 1.
  - Each bit lasts 4 cycles; first low appears 1 cycle after the send edge.
  - done pulses 80 cycles after the first low; busy is high for exactly those 80 cycles.
- Ignored request: during the previous word, toggle send 0→1 and set tx_data=16'h1111 → no change to serial output, word count unchanged, and only one done pulse.
- Back-to-back: raise send again in the done cycle with tx_data=16'h00FF → new start bit the next cycle; bytes 0xFF then 0x00 observed.
- WORD_BYTES=1, tx_data=16'hBE81 → only byte 0x81 sent; done after 40 cycles (CLKS_PER_BIT=4).
- Reset mid-operation: assert n_reset=0 during DATA bit 3 of byte 0 → next edge uart_tx=1, busy=0, no done; a fresh send afterward transmits normally from byte 0.
